// File: rtl/eindopdracht_pio_leds.sv
// eindopdracht_pio_leds: Avalon-MM LED output PIO with set/clear writes and per-bit blinking
module eindopdracht_pio_leds #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               PERIOD_WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);
   logic [WIDTH-1:0]        data, data_nxt, blink_en;
   logic [PERIOD_WIDTH-1:0] period, cnt;
   logic                    phase, wr;
   logic [31:0]             rd_mux;
   assign wr = chipselect & ~write_n;
   always_comb begin
      data_nxt = !wr ? data :
                 address == 3'd0 ? writedata[WIDTH-1:0] :
                 address == 3'd4 ? data | writedata[WIDTH-1:0] :
                 address == 3'd5 ? data & ~writedata[WIDTH-1:0] : data;
      rd_mux = address == 3'd0 ? 32'(data) :
               address == 3'd1 ? 32'(blink_en) :
               address == 3'd2 ? 32'(period) :
               address == 3'd6 ? {30'b0, period != '0, phase} : 32'b0;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data     <= RESET_VALUE;
         blink_en <= '0;
         period   <= '0;
         cnt      <= '0;
         phase    <= 1'b1;
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         data     <= data_nxt;
         readdata <= rd_mux;
         out_port <= (data & ~blink_en) | (data & blink_en & {WIDTH{phase}});
         if (wr && address == 3'd1)
            blink_en <= writedata[WIDTH-1:0];
         if (wr && address == 3'd2) begin
            period <= writedata[PERIOD_WIDTH-1:0];
            cnt    <= '0;
            phase  <= 1'b1;
         end else if (period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
         end else if (cnt == period - PERIOD_WIDTH'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
         end else
            cnt <= cnt + PERIOD_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_eindopdracht_pio_leds.sv
// tb_eindopdracht_pio_leds: vector table plus blink/reset sequences for the LED PIO
module tb_eindopdracht_pio_leds;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0, write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   int          n_tests = 0, n_fail = 0;
   logic [39:0] sb[$];
   typedef struct {
      string       name;
      bit          we;
      bit          cs;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [2:0]  ra;
      logic [31:0] er;
      logic [7:0]  eo;
   } vec_t;
   vec_t vt[15];
   always #5 clk = ~clk;
   eindopdracht_pio_leds #(.WIDTH(8), .RESET_VALUE(8'hA5), .PERIOD_WIDTH(24)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs);
      address = a; writedata = d; chipselect = cs; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask
   task automatic step(input string name, input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
      logic [39:0] e;
      address = a;
      sb.push_back({eo, er});
      @(posedge clk); #1;
      e = sb.pop_front();
      check({name, " readdata"}, readdata, e[31:0]);
      check({name, " out_port"}, {24'b0, out_port}, {24'b0, e[39:32]});
   endtask
   initial begin
      logic e;
      vt = '{
         '{"rst_data",  0, 1, 3'd0, 32'h0,         3'd0, 32'hA5, 8'hA5},
         '{"rst_stat",  0, 1, 3'd0, 32'h0,         3'd6, 32'h1,  8'hA5},
         '{"wr_data",   1, 1, 3'd0, 32'hFFFFFF0F, 3'd0, 32'h0F, 8'h0F},
         '{"outset",    1, 1, 3'd4, 32'h000000F0, 3'd0, 32'hFF, 8'hFF},
         '{"outclear",  1, 1, 3'd5, 32'h00000081, 3'd4, 32'h0,  8'h7E},
         '{"rd_data",   0, 1, 3'd0, 32'h0,         3'd0, 32'h7E, 8'h7E},
         '{"rd_clr",    0, 1, 3'd0, 32'h0,         3'd5, 32'h0,  8'h7E},
         '{"wr_blink",  1, 1, 3'd1, 32'hFFFFFF3C, 3'd1, 32'h3C, 8'h7E},
         '{"wr_a3",     1, 1, 3'd3, 32'hFFFFFFFF, 3'd3, 32'h0,  8'h7E},
         '{"wr_a7",     1, 1, 3'd7, 32'hFFFFFFFF, 3'd7, 32'h0,  8'h7E},
         '{"wr_stat",   1, 1, 3'd6, 32'hFFFFFFFF, 3'd6, 32'h1,  8'h7E},
         '{"no_cs",     1, 0, 3'd0, 32'h0,         3'd0, 32'h7E, 8'h7E},
         '{"wr_period", 1, 1, 3'd2, 32'h01000003, 3'd2, 32'h3,  8'h7E},
         '{"period0",   1, 1, 3'd2, 32'h0,         3'd2, 32'h0,  8'h7E},
         '{"blink0",    1, 1, 3'd1, 32'h0,         3'd1, 32'h0,  8'h7E}
      };
      repeat (2) @(posedge clk);
      #1;
      check("reset out_port", {24'b0, out_port}, 32'hA5);
      check("reset readdata", readdata, 32'h0);
      reset_n = 1'b1;
      foreach (vt[i]) begin
         if (vt[i].we) wr(vt[i].wa, vt[i].wd, vt[i].cs);
         step(vt[i].name, vt[i].ra, vt[i].eo, vt[i].er);
      end
      // period 3: three cycles high, three low, status bit0 follows phase
      wr(3'd0, 32'hFF, 1'b1);
      wr(3'd1, 32'h01, 1'b1);
      wr(3'd2, 32'h3, 1'b1);
      for (int k = 1; k <= 12; k++) begin
         e = ((k - 1) / 3) % 2 == 0;
         step("blink3", 3'd6, {7'h7F, e}, {30'b0, 1'b1, e});
      end
      // retune while phase=0, cnt=1: phase restarts high for exactly 5 cycles
      wr(3'd2, 32'h3, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         e = k <= 3;
         step("pre_retune", 3'd6, {7'h7F, e}, {30'b0, 1'b1, e});
      end
      wr(3'd2, 32'h5, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         e = k <= 5;
         step("blink5", 3'd6, {7'h7F, e}, {30'b0, 1'b1, e});
      end
      wr(3'd2, 32'h0, 1'b1);
      for (int k = 1; k <= 8; k++) step("stopped", 3'd6, 8'hFF, 32'h1);
      // async reset mid-blink with a write pending across the reset edge
      wr(3'd1, 32'hFF, 1'b1);
      wr(3'd2, 32'h4, 1'b1);
      for (int k = 1; k <= 5; k++) step("blink4", 3'd6, k <= 4 ? 8'hFF : 8'h00, k <= 4 ? 32'h3 : 32'h2);
      #2 reset_n = 1'b0;
      address = 3'd0; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
      #1;
      check("async out_port", {24'b0, out_port}, 32'hA5);
      check("async readdata", readdata, 32'h0);
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      check("held out_port", {24'b0, out_port}, 32'hA5);
      #2 reset_n = 1'b1;
      for (int k = 1; k <= 10; k++) step("post_rst", 3'd0, 8'hA5, 32'hA5);
      step("post_blink", 3'd1, 8'hA5, 32'h0);
      step("post_period", 3'd2, 8'hA5, 32'h0);
      step("post_stat", 3'd6, 8'hA5, 32'h1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/eindopdracht_pio_leds.md
Name: eindopdracht_pio_leds

Overview:
Avalon-MM slave output PIO that drives board LEDs. It is the output-direction counterpart of the button input PIO on the same interconnect.
- Holds a DATA register that software can write whole, or modify with atomic bit-set and bit-clear writes.
- Adds a per-bit blink function driven by one shared, programmable half-period counter.
- out_port is registered, so the LEDs never see combinational glitches.

Parameters:
WIDTH, 8, number of output bits (1..32); register bits above WIDTH-1 read as 0 and ignore writes.
RESET_VALUE, 0, value of DATA after reset.
PERIOD_WIDTH, 24, width of the PERIOD register and the blink counter (1..32).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  reset, asynchronous assert, active-low; all registers are cleared to their reset values.
address  input  3  word address within the slave.
chipselect  input  1  slave select.
write_n  input  1  write strobe, active-low; a write is chipselect && ~write_n.
writedata  input  32  write data.
readdata  output  32  registered read data; reset value 0.
out_port  output  WIDTH  LED drive; reset value RESET_VALUE.

Behaviour:
- Register map (word address, access, function):
  - 0, RW, DATA.
  - 1, RW, BLINK_EN mask.
  - 2, RW, PERIOD (half-period in clk cycles, low PERIOD_WIDTH bits).
  - 3, reads 0, writes ignored.
  - 4, W, OUTSET: DATA <= DATA | writedata[WIDTH-1:0].
  - 5, W, OUTCLEAR: DATA <= DATA & ~writedata[WIDTH-1:0].
  - 6, R, STATUS: bit0 = phase, bit1 = (PERIOD != 0), other bits 0.
  - 7, reads 0, writes ignored.
  - Addresses 4 and 5 read 0.
- Reset values: DATA = RESET_VALUE, BLINK_EN = 0, PERIOD = 0, cnt = 0, phase = 1, readdata = 0, out_port = RESET_VALUE.
- Read path:
  - readdata is updated on every clock edge from the address mux, independent of chipselect; unused upper bits are 0.
  - Read latency is 1 cycle: data is valid the cycle after address is presented.
- Write timing:
  - A write takes effect at the clock edge where it is sampled; no wait states.
  - Only one write per cycle, so OUTSET and OUTCLEAR cannot collide.
- Blink counter:
  - If PERIOD == 0: cnt is held at 0 and phase is held at 1, so blinking is disabled.
  - Otherwise cnt increments every cycle. When cnt == PERIOD-1, cnt <= 0 and phase toggles on the same edge. Each phase therefore lasts exactly PERIOD cycles.
  - A write to PERIOD, on that edge, loads PERIOD, sets cnt <= 0 and phase <= 1. The write wins over a simultaneous wrap.
  - Because cnt restarts, lowering PERIOD below the current cnt is safe.
  - Writes to DATA, BLINK_EN, OUTSET or OUTCLEAR do not affect cnt or phase.
- Output:
  - out_port[i] <= BLINK_EN[i] ? (DATA[i] & phase) : DATA[i], registered.
  - out_port reflects a register write one edge after the write edge.
  - A blinked bit whose DATA bit is 0 stays 0.
- Reset asserted mid-blink or mid-write: immediate return to the reset values; no pending write survives.

Test Plan:
1. Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5 and readdata=0 while reset_n=0. Read addr 0 after release -> 32'h000000A5. Read addr 6 -> 32'h1.
2. Write DATA=32'hFFFF_FF0F (WIDTH=8) at edge k -> out_port=8'h0F after edge k+1. Read addr 0 -> 32'h0000000F.
3. From DATA=8'h0F: OUTSET 8'hF0 -> DATA=8'hFF. Then OUTCLEAR 8'h81 -> DATA=8'h7E, out_port=8'h7E. Read addr 4 -> 0.
4. DATA=8'hFF, BLINK_EN=8'h01, PERIOD=3 -> out_port[0] gives exactly 3 cycles at 1, then 3 cycles at 0, repeating. out_port[7:1] stays 7'h7F. STATUS bit0 tracks phase.
5. While phase=0 with cnt=1: write PERIOD=5 -> phase=1 and cnt=0 on that edge, next toggle after exactly 5 cycles. Then write PERIOD=0 -> phase held 1, out_port=DATA steadily, STATUS=32'h1.
6. Assert reset_n=0 for 1 cycle mid-blink (PERIOD=4, BLINK_EN=8'hFF) -> PERIOD=0, BLINK_EN=0, out_port=RESET_VALUE, no further toggling.
